fetch_pair: RTL
===============

FETCH_PAIR -- requirements
Module: fetch_pair

Interface
REQ-001 Parameter QDEPTH, default 8, instruction-queue entries (power of two, >=4).
REQ-002 CLK  input  1  clock, all state updates on posedge.
REQ-003 NRST  input  1  reset, synchronous, active-low.
REQ-004 stall  input  1  pipeline hold; no queue pop while high.
REQ-005 is_depend  input  1  pair-split flag from dependency checker, same cycle as outputs.
REQ-006 fail_predict  input  1  redirect/flush request.
REQ-007 redirect_pc  input  13  byte address to resume fetch when fail_predict=1.
REQ-008 imem_req  output  1  instruction-memory read strobe.
REQ-009 imem_addr  output  10  8-byte line index (fetch_pc[12:3]).
REQ-010 imem_rdata  input  64  line data, valid exactly 1 cycle after imem_req; [31:0] word at line+0, [63:32] at line+4.
REQ-011 pc1_out, inst1_out  output  13/32  slot-0 pc/instruction to checker.
REQ-012 pc2_out, inst2_out  output  13/32  slot-1 pc/instruction to checker.
REQ-013 bubble  output  1  queue cannot supply required slots; outputs are zero this cycle.

Function
REQ-014 Queue SHALL be a circular FIFO of QDEPTH {pc,inst} entries with head, tail, count (0..QDEPTH).
REQ-015 slip SHALL be a register: next = is_depend when !stall; held when stall; 0 on reset or fail_predict.
REQ-016 need SHALL be 1 when slip=1, else 2.
REQ-017 bubble SHALL be 1 when count < need; then pc1/inst1/pc2/inst2 outputs = 0 and nothing is popped.
REQ-018 When bubble=0: slot0 = head entry; slot1 = head+1 entry if need=2, else pc2_out=0, inst2_out=0.
REQ-019 Pop SHALL occur when !stall && !bubble && !fail_predict; pop count = need; head advances modulo QDEPTH.
REQ-020 imem_req SHALL be 1 when !fail_predict && (QDEPTH - count - 2*inflight) >= 2 after accounting for this cycle's pop; inflight is the 1-bit registered imem_req.
REQ-021 Response write (cycle after imem_req, unless cancelled): if req_pc[2]=0 write two entries {req_pc, rdata[31:0]}, {req_pc+4, rdata[63:32]}; if req_pc[2]=1 write one entry {req_pc, rdata[63:32]}.
REQ-022 After each request, fetch_pc SHALL advance to {fetch_pc[12:3]+1, 3'b000}; 13-bit wrap from 0x1FF8 to 0x0000.
REQ-023 Pop and write in the same cycle SHALL both take effect; count_next = count - pops + writes, never exceeding QDEPTH.
REQ-024 fail_predict=1: queue emptied (count=0, head=tail), fetch_pc <= {redirect_pc[12:2],2'b00}, in-flight response cancelled (not written), imem_req=0, no pop; fetch restarts next cycle.
REQ-025 fail_predict has priority over stall, pop and write in the same cycle.
REQ-026 stall SHALL NOT block imem requests or response writes while space permits.
REQ-027 Instruction words SHALL pass unmodified; inst value 0 is the pipeline bubble encoding.

Reset
REQ-028 NRST=0 at posedge: fetch_pc=0, count=0, head=tail=0, slip=0, inflight=0, cancel=0.
REQ-029 During and first cycle after reset: imem_req=0, bubble=1, all pc/inst outputs 0.
REQ-030 Reset mid-operation SHALL discard queue contents and any in-flight response.

Verification
REQ-031 Reset release, imem returns words W0..Wn at addresses 0,4,...: first request cycle 1, imem_addr=0; bubble low from cycle 3, pc1_out=0x000/inst1=W0, pc2_out=0x004/inst2=W1.
REQ-032 Steady stream, is_depend pulsed once while pair (0x010,0x014) shown: next cycle need=1, pc1_out=0x018, pc2_out=0, inst2_out=0; following cycle pair (0x01C,0x020).
REQ-033 stall held 3 cycles with queue full: outputs constant, count=QDEPTH, imem_req=0; after release pops resume, no entry lost or duplicated.
REQ-034 fail_predict with redirect_pc=0x0A4 while response in flight: next cycle count=0, bubble=1; next request imem_addr=0x014; first output pc1_out=0x0A4 with word at +4 of line, pc2_out=0x0A8.
REQ-035 count=1, slip=0: bubble=1, outputs 0, no pop; entry popped with its successor once second word arrives.
REQ-036 Fetch across 0x1FF8: after line 0x3FF next imem_addr=0x000; pcs wrap 0x1FFC -> 0x0000 in order.

Source files
------------

// File: rtl/fetch_pair.sv
// fetch_pair: instruction fetch unit feeding a two-wide issue stage.
// It fetches 8-byte lines from instruction memory into a circular queue of
// {pc, inst} entries. Each cycle it presents the head entry (slot 0) and,
// unless the previous pair was split, the entry after it (slot 1).
//
// Ports:
//   CLK, NRST           clock, synchronous active-low reset
//   stall               hold: no pop while high (fetch continues)
//   is_depend           pair-split flag from the dependency checker
//   fail_predict        flush the queue and redirect fetch to redirect_pc
//   redirect_pc[12:0]   byte address to resume fetch from
//   imem_req            instruction-memory read strobe
//   imem_addr[9:0]      8-byte line index being requested
//   imem_rdata[63:0]    line data, valid the cycle after imem_req
//   pc1_out/inst1_out   slot-0 pc/instruction (zero on bubble)
//   pc2_out/inst2_out   slot-1 pc/instruction (zero on bubble or split)
//   bubble              queue cannot supply the slots needed this cycle
module fetch_pair #(
  parameter int QDEPTH = 8
) (
  input  logic        CLK,
  input  logic        NRST,
  input  logic        stall,
  input  logic        is_depend,
  input  logic        fail_predict,
  input  logic [12:0] redirect_pc,
  output logic        imem_req,
  output logic [9:0]  imem_addr,
  input  logic [63:0] imem_rdata,
  output logic [12:0] pc1_out,
  output logic [31:0] inst1_out,
  output logic [12:0] pc2_out,
  output logic [31:0] inst2_out,
  output logic        bubble
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;  // count spans 0..QDEPTH
  localparam int SW = CW + 2;  // headroom for the free-space comparison

  typedef struct packed {
    logic [12:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t          entries [QDEPTH];
  logic [AW-1:0]   head, tail;
  logic [CW-1:0]   count;
  logic [12:0]     fetch_pc;
  logic [12:0]     req_pc;     // address of the line currently in flight
  logic            inflight;
  logic            slip;       // previous issue was split: only one slot now
  logic            run;        // holds off the first request for one cycle after reset

  logic [1:0]      need, pops, writes;
  logic            pop, wr_en;
  logic [AW-1:0]   head_p1, tail_p1;
  logic [SW-1:0]   space_avail, space_need;
  entry_t          slot0, slot1;

  assign need    = slip ? 2'd1 : 2'd2;
  assign bubble  = !NRST || (count < CW'(need));
  assign pop     = NRST && !stall && !bubble && !fail_predict;
  assign pops    = pop ? need : 2'd0;

  // A flush discards whatever line arrives in the same cycle.
  assign wr_en   = inflight && !fail_predict;
  assign writes  = !wr_en ? 2'd0 : (req_pc[2] ? 2'd1 : 2'd2);

  // Request only when a full line still fits after this cycle's pop and
  // after the line already in flight lands.
  assign space_avail = SW'(QDEPTH) + SW'(pops);
  assign space_need  = SW'(count) + (inflight ? SW'(4) : SW'(2));
  assign imem_req    = NRST && run && !fail_predict && (space_avail >= space_need);
  assign imem_addr   = fetch_pc[12:3];

  assign head_p1 = head + 1'b1;
  assign tail_p1 = tail + 1'b1;
  assign slot0   = entries[head];
  assign slot1   = entries[head_p1];

  // NOTE: combinational outputs use continuous assigns (or always_comb with a
  // default first) so no path can leave a value unassigned and infer a latch.
  assign pc1_out   = bubble ? '0 : slot0.pc;
  assign inst1_out = bubble ? '0 : slot0.inst;
  assign pc2_out   = (bubble || slip) ? '0 : slot1.pc;
  assign inst2_out = (bubble || slip) ? '0 : slot1.inst;

  // NOTE: the queue storage has no reset; validity is tracked entirely by
  // head/tail/count, so clearing the array would only cost flops.
  always_ff @(posedge CLK) begin
    if (NRST && wr_en) begin
      if (req_pc[2]) begin
        // Fetch entered mid-line: only the upper word belongs to the stream.
        entries[tail] <= '{pc: req_pc, inst: imem_rdata[63:32]};
      end else begin
        entries[tail]    <= '{pc: req_pc, inst: imem_rdata[31:0]};
        entries[tail_p1] <= '{pc: {req_pc[12:3], 3'b100}, inst: imem_rdata[63:32]};
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the clock edge.
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      fetch_pc <= '0;
      req_pc   <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      slip     <= 1'b0;
      inflight <= 1'b0;
      run      <= 1'b0;
    end else begin
      run      <= 1'b1;
      inflight <= imem_req;
      if (imem_req) begin
        req_pc <= fetch_pc;
      end
      if (fail_predict) begin
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        slip     <= 1'b0;
        fetch_pc <= redirect_pc & ~13'd3;
      end else begin
        if (!stall) begin
          slip <= is_depend;
        end
        head  <= head + AW'(pops);
        tail  <= tail + AW'(writes);
        count <= count - CW'(pops) + CW'(writes);
        if (imem_req) begin
          fetch_pc <= {fetch_pc[12:3] + 10'd1, 3'b000};
        end
      end
    end
  end

endmodule
